stream_ram_writer: RTL and testbench
====================================

Name: stream_ram_writer

Overview:
- Writer-side counterpart to the registered-ROM-read structure used in the showcase components.
- Accepts a valid/ready data stream, packs one frame into a small internal RAM at auto-incrementing addresses, then freezes the frame and exposes it through a registered read port with 1-cycle latency.
- Sits between a stream producer and any consumer that addresses frame words randomly.

Parameters:
- DATA_WIDTH, 8, width of stream word and RAM word
- ADDR_WIDTH, 2, RAM address width; DEPTH = 2**ADDR_WIDTH (default 4 words)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- din_data  in  DATA_WIDTH  stream word
- din_last  in  1  last word of frame, qualified by din_vld
- din_vld  in  1  producer has a word
- din_rd  out  1  block accepts a word this cycle
- clear  in  1  discard current frame, return to FILL
- full  out  1  frame captured, RAM frozen
- frame_done  out  1  single-cycle pulse when a frame is captured
- count  out  ADDR_WIDTH+1  number of words written in current frame
- rd_en  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  registered read data

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk.
  - When rst_n == 0 at a clk rising edge: state = FILL, wr_ptr = 0, count = 0, full = 0, frame_done = 0, rd_data = 0.
  - RAM contents are not cleared.
- States: FILL, DONE; 1-bit state register.
- din_rd = (state == FILL) && !clear. It is combinational and does not depend on din_vld.
- Handshake: a word transfers on a rising edge where din_vld && din_rd.
  - The producer holds din_data and din_last stable while din_vld && !din_rd.
- FILL, on transfer:
  - mem[wr_ptr] <= din_data; wr_ptr <= wr_ptr + 1 (wraps to 0 on DEPTH); count <= count + 1.
  - If din_last || wr_ptr == DEPTH-1: next state DONE, full <= 1, frame_done <= 1 for exactly one cycle.
  - A frame longer than DEPTH is truncated. Words after the DEPTH-th are stalled (din_rd = 0 in DONE), not dropped.
- DONE: din_rd = 0; no RAM writes; count and full hold.
- clear, in either state: next state FILL, wr_ptr <= 0, count <= 0, full <= 0.
  - clear has priority over a simultaneous transfer; no write occurs because din_rd = 0.
  - frame_done is not asserted.
- Simultaneous final transfer and clear: not possible, since clear masks din_rd.
- Read port:
  - rd_en == 1: rd_data <= mem[rd_addr] on the next edge, so rd_data is valid 1 cycle after the request.
  - rd_en == 0: rd_data holds.
  - Reads are allowed in any state.
  - Read and write to the same address in the same cycle returns the old data (read-first).
- frame_done goes high in the cycle after the capturing transfer, aligned with full rising. It deasserts the following cycle.
- Reset mid-frame: the partial frame is abandoned and count returns to 0. The next frame overwrites from address 0.
- count range is 0..DEPTH, hence ADDR_WIDTH+1 bits. wr_ptr is internal, ADDR_WIDTH bits.

Decomposition:
- Shared package: state enum (FILL, DONE) and a helper constant DEPTH = 2**ADDR_WIDTH.
- One natural sub-module, ram_1w1r_sync: single write port, single registered read port, read-first.
  - Holds mem[] and rd_data.
  - Parent holds the FSM, pointer, count and handshake.

Test Plan:
- Reset check: hold rst_n = 0 for 2 cycles.
  - Expect full = 0, frame_done = 0, count = 0, rd_data = 0, and din_rd = 1 after release.
- Full-depth frame: stream 0x11, 0x22, 0x33, 0x44 with din_vld held high and din_last only on 0x44.
  - Expect a frame_done pulse one cycle after the 4th transfer, full = 1, count = 4, din_rd = 0.
  - Then rd_en with rd_addr 0..3 returns 0x11, 0x22, 0x33, 0x44, each 1 cycle after its request.
- Short frame: stream 0xA0, 0xA1 with din_last on 0xA1.
  - Expect count = 2, full = 1, and rd_addr = 1 returns 0xA1.
  - Addresses 2..3 keep their old contents.
- Overlong frame: 6 words with no din_last.
  - Expect capture after 4 words, din_rd = 0 while words 5 and 6 are held valid, count = 4.
  - After clear, word 5 is accepted into address 0.
- Clear priority: assert clear together with din_vld in FILL after 2 words.
  - Expect no write (mem[2] unchanged), count = 0, no frame_done.
  - The next word lands at address 0.
- Read-first collision and mid-frame reset:
  - Read address 1 in the same cycle that 0x5A is written to address 1: expect the old value, then 0x5A on a re-read.
  - Pulse rst_n = 0 after 3 words: expect count = 0, full = 0, and the next frame starts at address 0.

Source files
------------

// File: rtl/stream_ram_writer_pkg.sv
// Shared types for the stream-to-RAM frame writer.
package stream_ram_writer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        DONE = 1'b1
    } state_e;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/stream_ram_writer_ram_1w1r_sync.sv
// Single write port, single registered read port RAM; read-first on address collision.
module stream_ram_writer_ram_1w1r_sync
    import stream_ram_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/stream_ram_writer.sv
// Packs one valid/ready frame into a small RAM, then freezes it for random-access reads.
module stream_ram_writer
    import stream_ram_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic                  din_last,
    input  logic                  din_vld,
    output logic                  din_rd,
    input  logic                  clear,
    output logic                  full,
    output logic                  frame_done,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_d;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic                  full_q;
    logic                  frame_done_q;
    logic                  wr_fire;
    logic                  capture;

    assign din_rd   = (state_q == FILL) && !clear;
    assign wr_fire  = din_vld && din_rd;
    assign wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    assign count_d  = count_q + (ADDR_WIDTH + 1)'(1);
    // Last slot ends the frame even without din_last; excess words stall.
    assign capture  = din_last || (wr_ptr_q == ADDR_WIDTH'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= FILL;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (clear) begin
                state_q  <= FILL;
                wr_ptr_q <= '0;
                count_q  <= '0;
                full_q   <= 1'b0;
            end else if (wr_fire) begin
                wr_ptr_q <= wr_ptr_d;
                count_q  <= count_d;
                if (capture) begin
                    state_q      <= DONE;
                    full_q       <= 1'b1;
                    frame_done_q <= 1'b1;
                end
            end
        end
    end

    stream_ram_writer_ram_1w1r_sync #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_fire && rst_n),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (din_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign full       = full_q;
    assign frame_done = frame_done_q;
    assign count      = count_q;

endmodule

// File: tb/tb_stream_ram_writer.sv
// Scoreboarded bench for stream_ram_writer: behavioural model plus read-data queue.
module tb_stream_ram_writer;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] din_data;
    logic          din_last;
    logic          din_vld;
    logic          din_rd;
    logic          clear;
    logic          full;
    logic          frame_done;
    logic [AW:0]   count;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mdl_mem [DEPTH];
    int            mdl_ptr;
    int            mdl_cnt;
    bit            mdl_full;
    bit            mdl_fd;
    logic [DW-1:0] mdl_rd;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    stream_ram_writer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_data   (din_data),
        .din_last   (din_last),
        .din_vld    (din_vld),
        .din_rd     (din_rd),
        .clear      (clear),
        .full       (full),
        .frame_done (frame_done),
        .count      (count),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: predict from current inputs, advance, then compare all outputs.
    task automatic tick();
        bit xfer;
        bit rd_req;
        int wr_addr;
        #1;
        if (rst_n) check("din_rd", 32'(din_rd), 32'(!mdl_full && !clear));
        xfer   = rst_n && din_vld && !mdl_full && !clear;
        rd_req = rst_n && rd_en;
        if (rd_req) exp_q.push_back(mdl_mem[rd_addr]);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mdl_ptr  = 0;
            mdl_cnt  = 0;
            mdl_full = 0;
            mdl_fd   = 0;
            mdl_rd   = '0;
            exp_q.delete();
        end else begin
            mdl_fd = 0;
            if (clear) begin
                mdl_ptr  = 0;
                mdl_cnt  = 0;
                mdl_full = 0;
            end else if (xfer) begin
                wr_addr = mdl_ptr;
                mdl_mem[wr_addr] = din_data;
                mdl_ptr = (mdl_ptr + 1) % DEPTH;
                mdl_cnt++;
                if (din_last || mdl_ptr == 0) begin
                    mdl_full = 1;
                    mdl_fd   = 1;
                end
                $display("xfer addr=%0d data=%02h last=%0d", wr_addr, din_data, din_last);
            end
            if (rd_req) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    mdl_rd = exp_q.pop_front();
                    $display("read data=%02h exp=%02h", rd_data, mdl_rd);
                end
            end
        end
        check("full", 32'(full), 32'(mdl_full));
        check("frame_done", 32'(frame_done), 32'(mdl_fd));
        check("count", 32'(count), 32'(mdl_cnt));
        check("rd_data", 32'(rd_data), 32'(mdl_rd));
    endtask

    task automatic push_word(input logic [DW-1:0] d, input bit last);
        din_vld  = 1'b1;
        din_data = d;
        din_last = last;
        tick();
    endtask

    task automatic idle();
        din_vld  = 1'b0;
        din_last = 1'b0;
        rd_en    = 1'b0;
        clear    = 1'b0;
        tick();
    endtask

    task automatic read(input int a);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        tick();
        rd_en   = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] frame4 [4];
        logic [DW-1:0] longf [6];
        frame4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        longf  = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};

        rst_n = 1'b0; din_data = '0; din_last = 1'b0; din_vld = 1'b0;
        clear = 1'b0; rd_en = 1'b0; rd_addr = '0;
        mdl_ptr = 0; mdl_cnt = 0; mdl_full = 0; mdl_fd = 0; mdl_rd = '0;

        // Reset
        tick();
        tick();
        rst_n = 1'b1;
        idle();

        // Full-depth frame, then read back all four words
        for (int i = 0; i < 4; i++) push_word(frame4[i], i == 3);
        idle();
        for (int a = 0; a < 4; a++) read(a);
        idle();

        // Short frame: addresses 2..3 keep old contents
        do_clear();
        push_word(8'hA0, 1'b0);
        push_word(8'hA1, 1'b1);
        idle();
        for (int a = 1; a < 4; a++) read(a);
        idle();

        // Overlong frame: word 5 stalls until clear, then lands at address 0
        do_clear();
        for (int i = 0; i < 4; i++) push_word(longf[i], 1'b0);
        for (int i = 0; i < 3; i++) push_word(longf[4], 1'b0);
        clear = 1'b1;
        push_word(longf[4], 1'b0);
        clear = 1'b0;
        push_word(longf[4], 1'b0);
        push_word(longf[5], 1'b0);
        idle();
        read(0);
        read(1);
        idle();

        // Clear priority over a simultaneous valid word
        do_clear();
        push_word(8'hB0, 1'b0);
        push_word(8'hB1, 1'b0);
        clear = 1'b1;
        push_word(8'hCC, 1'b0);
        clear = 1'b0;
        push_word(8'hD0, 1'b0);
        din_vld = 1'b0;
        read(2);
        read(0);
        idle();

        // Read-first collision at address 1, then re-read
        rd_en   = 1'b1;
        rd_addr = AW'(1);
        push_word(8'h5A, 1'b0);
        din_vld = 1'b0;
        read(1);
        idle();

        // Mid-frame reset: next frame starts at address 0
        do_clear();
        for (int i = 0; i < 3; i++) push_word(8'hC0 + DW'(i), 1'b0);
        din_vld = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        push_word(8'hE0, 1'b1);
        idle();
        read(0);
        read(1);
        idle();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
